param_updown_cnt: RTL and testbench

Parametrised up/down counter with programmable bounds, enable, synchronous load and a direction flag. It replaces the fixed 8-bit free-running counter in the counter/timer family. Modes are up-wrap, down-wrap, triangle (ping-pong, direction flag reverses at each bound) and hold. Used as a timebase, PWM carrier and address sequencer.

---
 rtl/param_updown_cnt.sv | 163 ++++++++++++++++
 tb/tb_param_updown_cnt.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/param_updown_cnt.sv
// param_updown_cnt
//   Parametrised up/down counter with programmable inclusive bounds, count
//   enable, synchronous load and a registered direction flag. Supported modes
//   are up-wrap, down-wrap, triangle (ping-pong) and hold. It is used as a
//   timebase, as a PWM carrier and as an address sequencer.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   RST_VAL  counter value on reset
//
// Ports
//   sclk      in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   en        in   count enable, one step per sclk while high
//   mode      in   0 up-wrap, 1 down-wrap, 2 triangle, 3 hold
//   load      in   synchronous load strobe (overrides en, mode and bounds)
//   load_val  in   value written on load
//   lo        in   lower bound (inclusive)
//   hi        in   upper bound (inclusive)
//   cnt       out  registered count value
//   dir       out  registered direction: 0 counting up, 1 counting down
//   wrap      out  registered one-cycle pulse on bound turnover
//   cfg_err   out  registered, high while lo > hi
module param_updown_cnt #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             wrap,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  // In triangle mode the direction flag is the state bit.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e            mode_s;
  logic             bounds_bad;
  logic             out_of_range;

  logic [WIDTH-1:0] cnt_q,     cnt_d;
  dir_e             dir_q,     dir_d;
  logic             wrap_q,    wrap_d;
  logic             cfg_err_q, cfg_err_d;

  assign mode_s       = mode_e'(mode);
  // Bound checks use the live bound inputs, so a bound change affects the
  // very next step without a cycle of delay.
  assign bounds_bad   = (lo > hi);
  assign out_of_range = (cnt_q < lo) || (cnt_q > hi);

  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    wrap_d    = 1'b0;
    cfg_err_d = bounds_bad;

    if (load) begin
      cnt_d = load_val;
    end else if (bounds_bad) begin
      // Inconsistent bounds: freeze count and direction until fixed.
      cnt_d = cnt_q;
    end else if (en) begin
      if (mode_s == MODE_HOLD) begin
        cnt_d = cnt_q;
      end else if (out_of_range) begin
        // Re-enter the window at the bound the mode starts from.
        if (mode_s == MODE_DOWN) begin
          cnt_d = hi;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = lo;
          dir_d = DIR_UP;
        end
      end else begin
        unique case (mode_s)
          MODE_UP: begin
            dir_d = DIR_UP;
            if (cnt_q == hi) begin
              cnt_d  = lo;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
          MODE_DOWN: begin
            dir_d = DIR_DOWN;
            if (cnt_q == lo) begin
              cnt_d  = hi;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
          MODE_TRI: begin
            if (lo == hi) begin
              // Degenerate window: nowhere to move, but every step turns over.
              wrap_d = 1'b1;
            end else if (dir_q == DIR_UP) begin
              if (cnt_q == hi) begin
                // Reflect so the bound value is emitted only once per period.
                dir_d  = DIR_DOWN;
                cnt_d  = hi - WIDTH'(1);
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q + WIDTH'(1);
              end
            end else begin
              if (cnt_q == lo) begin
                dir_d  = DIR_UP;
                cnt_d  = lo + WIDTH'(1);
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q - WIDTH'(1);
              end
            end
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt_q     <= RST_VAL;
      dir_q     <= DIR_UP;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cnt     = cnt_q;
  assign dir     = dir_q;
  assign wrap    = wrap_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_param_updown_cnt.sv
// tb_param_updown_cnt
//   Directed testbench for param_updown_cnt (WIDTH=8, RST_VAL=0). The driver
//   applies inputs on the falling edge and queues the hand-computed register
//   state expected after the next rising edge (or after an asynchronous reset
//   edge). An independent monitor pops one entry per rising sclk/rst edge and
//   compares it against the DUT outputs.
module tb_param_updown_cnt;

  localparam int W = 8;

  logic         sclk = 1'b0;
  logic         rst  = 1'b1;
  logic         en   = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = '1;
  logic [W-1:0] cnt;
  logic         dir;
  logic         wrap;
  logic         cfg_err;

  typedef struct {
    logic [W-1:0] cnt;
    logic         dir;
    logic         wrap;
    logic         cfg;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  param_updown_cnt #(.WIDTH(W), .RST_VAL(8'd0)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .lo       (lo),
    .hi       (hi),
    .cnt      (cnt),
    .dir      (dir),
    .wrap     (wrap),
    .cfg_err  (cfg_err)
  );

  always #5 sclk = ~sclk;

  function automatic exp_t mk(input logic [W-1:0] c, input logic d,
                              input logic w, input logic f, input string nm);
    exp_t e;
    e.cnt = c; e.dir = d; e.wrap = w; e.cfg = f; e.name = nm;
    return e;
  endfunction

  // One clock of stimulus plus the state expected after the next rising edge.
  task automatic cyc(input logic e, input logic [1:0] m, input logic l,
                     input logic [W-1:0] lv, input logic [W-1:0] lo_v,
                     input logic [W-1:0] hi_v, input logic [W-1:0] c,
                     input logic d, input logic w, input logic f,
                     input string nm);
    @(negedge sclk);
    en = e; mode = m; load = l; load_val = lv; lo = lo_v; hi = hi_v;
    exp_q.push_back(mk(c, d, w, f, nm));
  endtask

  // Monitor: every rising sclk or rst edge presents a new register state.
  initial begin
    exp_t e;
    forever begin
      @(posedge sclk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (cnt !== e.cnt || dir !== e.dir || wrap !== e.wrap || cfg_err !== e.cfg) begin
          n_fail++;
          $display("FAIL %s: got cnt=%0d dir=%b wrap=%b cfg_err=%b, want cnt=%0d dir=%b wrap=%b cfg_err=%b",
                   e.name, cnt, dir, wrap, cfg_err, e.cnt, e.dir, e.wrap, e.cfg);
        end
      end
    end
  end

  initial begin
    // Reset state, sampled while rst is still held.
    cyc(0, 0, 0, 0, 0, 255,   0, 0, 0, 0, "reset_state");
    @(negedge sclk);
    rst = 1'b0;

    // Full-range up-wrap: 1..255, then 0 with wrap.
    for (int i = 1; i <= 256; i++) begin
      cyc(1, 0, 0, 0, 0, 255, W'(i), 0, (i == 256), 0, "up_wrap_full");
    end

    // Triangle lo=2 hi=5 from a load of 2.
    cyc(1, 2, 1, 2, 2, 5,  2, 0, 0, 0, "tri_load");
    cyc(1, 2, 0, 0, 2, 5,  3, 0, 0, 0, "tri_3");
    cyc(1, 2, 0, 0, 2, 5,  4, 0, 0, 0, "tri_4");
    cyc(1, 2, 0, 0, 2, 5,  5, 0, 0, 0, "tri_5");
    cyc(1, 2, 0, 0, 2, 5,  4, 1, 1, 0, "tri_turn_hi");
    cyc(1, 2, 0, 0, 2, 5,  3, 1, 0, 0, "tri_3_dn");
    cyc(1, 2, 0, 0, 2, 5,  2, 1, 0, 0, "tri_2_dn");
    cyc(1, 2, 0, 0, 2, 5,  3, 0, 1, 0, "tri_turn_lo");
    cyc(1, 2, 0, 0, 2, 5,  4, 0, 0, 0, "tri_4_up");
    cyc(1, 2, 0, 0, 2, 5,  5, 0, 0, 0, "tri_5_b");
    cyc(1, 2, 0, 0, 2, 5,  4, 1, 1, 0, "tri_at_4_dn");

    // Asynchronous reset between edges at cnt=4, dir=1.
    @(negedge sclk);
    en = 1'b0;
    #2;
    exp_q.push_back(mk(0, 0, 0, 0, "async_rst_immediate"));
    exp_q.push_back(mk(0, 0, 0, 0, "rst_held_edge"));
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    cyc(1, 2, 0, 0, 0, 5,  1, 0, 0, 0, "restart_1");
    cyc(1, 2, 0, 0, 0, 5,  2, 0, 0, 0, "restart_2");

    // Down-wrap and hold.
    cyc(1, 1, 1, 10, 10, 12, 10, 0, 0, 0, "dn_load_10");
    cyc(1, 1, 0, 0,  10, 12, 12, 1, 1, 0, "dn_wrap_12");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 10, 12, 12, 1, 0, 0, "en_low_hold");
    for (int i = 0; i < 2; i++) cyc(1, 3, 0, 0, 10, 12, 12, 1, 0, 0, "mode_hold");

    // Load precedence and out-of-range re-entry.
    cyc(1, 0, 1, 200, 4, 8, 200, 1, 0, 0, "load_200_over_en");
    cyc(1, 0, 0, 0,   4, 8,   4, 0, 0, 0, "oor_to_lo");
    cyc(1, 0, 1, 8,   4, 8,   8, 0, 0, 0, "load_8");
    cyc(1, 0, 0, 0,   4, 8,   4, 0, 1, 0, "wrap_8_to_4");
    cyc(1, 0, 0, 0,   4, 8,   5, 0, 0, 0, "up_5");

    // Configuration error freezes the count.
    cyc(1, 0, 0, 0, 9, 3, 5, 0, 0, 1, "cfg_err_set");
    cyc(1, 0, 0, 0, 9, 3, 5, 0, 0, 1, "cfg_err_frozen");
    cyc(1, 0, 0, 0, 3, 9, 6, 0, 0, 0, "cfg_err_clear");
    cyc(1, 0, 0, 0, 7, 9, 7, 0, 0, 0, "bound_move_oor");

    // Triangle with lo==hi: hold, wrap every enabled step.
    cyc(1, 2, 0, 0, 7, 7, 7, 0, 1, 0, "tri_degenerate_a");
    cyc(1, 2, 0, 0, 7, 7, 7, 0, 1, 0, "tri_degenerate_b");
    cyc(1, 3, 0, 0, 7, 7, 7, 0, 0, 0, "hold_after_degen");

    // Full-range down-wrap.
    cyc(1, 1, 1, 0, 0, 255,   0, 0, 0, 0, "dn_full_load0");
    cyc(1, 1, 0, 0, 0, 255, 255, 1, 1, 0, "dn_full_wrap");
    cyc(1, 1, 0, 0, 0, 255, 254, 1, 0, 0, "dn_full_254");
    cyc(0, 1, 0, 0, 0, 255, 254, 1, 0, 0, "final_idle");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge sclk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
